// File: rtl/ir_nec_rx.sv
// NEC infrared frame receiver: tick prescaler, windowed mark/space measurement, FWFT frame FIFO.
// Define IR_NEC_REPEAT_EN to turn repeat codes into re-pushes of the last good frame.
module ir_nec_rx #(
    parameter int DIV        = 1406,
    parameter int DEPTH      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_in,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [31:0] frame_data,
    output logic        frame_repeat,
    output logic        overflow,
    output logic        err,
    output logic        busy
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
`ifdef IR_NEC_REPEAT_EN
    localparam int EW = 33;
`else
    localparam int EW = 32;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE
`ifdef IR_NEC_REPEAT_EN
        , REPEAT_MARK
`endif
    } state_t;

    state_t        state;
    logic          s1, s2, s2_d;
    logic          mark, edge_det, mark_start, mark_end;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    width;
    logic [31:0]   shreg;
    logic [5:0]    bit_cnt;

    // Synchroniser flops reset to the idle line level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= IDLE_LVL;
            s2   <= IDLE_LVL;
            s2_d <= IDLE_LVL;
        end else begin
            s1   <= ir_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign mark       = s2 ^ IDLE_LVL;
    assign edge_det   = s2 ^ s2_d;
    assign mark_start = edge_det && mark;
    assign mark_end   = edge_det && !mark;

    assign tick = (presc == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width <= '0;
        end else if (state == IDLE || edge_det) begin
            width <= '0;
        end else if (tick && width != 8'd255) begin
            width <= width + 8'd1;
        end
    end

    logic w_lead_mark, w_lead_space, w_bit_mark, w_zero, w_one;
    assign w_lead_mark  = (width >= 8'd128) && (width <= 8'd192);
    assign w_lead_space = (width >= 8'd64)  && (width <= 8'd96);
    assign w_bit_mark   = (width >= 8'd5)   && (width <= 8'd15);
    assign w_zero       = (width >= 8'd5)   && (width <= 8'd15);
    assign w_one        = (width >= 8'd20)  && (width <= 8'd40);

    logic          frame_done, cksum_ok, push_req;
    logic [EW-1:0] push_entry;
    assign frame_done = (state == BIT_MARK) && mark_end && w_bit_mark && (bit_cnt == 6'd32);
    assign cksum_ok   = (shreg[31:24] == ~shreg[23:16]);

`ifdef IR_NEC_REPEAT_EN
    logic        w_rep_space, rep_done, last_valid;
    logic [31:0] last_frame;
    assign w_rep_space = (width >= 8'd32) && (width <= 8'd48);
    assign rep_done    = (state == REPEAT_MARK) && mark_end && w_bit_mark;
    assign push_req    = (frame_done && cksum_ok) || (rep_done && last_valid);
    assign push_entry  = rep_done ? {1'b1, last_frame} : {1'b0, shreg};
`else
    assign push_req    = frame_done && cksum_ok;
    assign push_entry  = shreg;
`endif

    // Protocol FSM: every edge is judged against the window for the state it closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
            last_frame <= '0;
            last_valid <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            if (state != IDLE && width == 8'd255) begin
                state <= IDLE;
                err   <= 1'b1;
            end else if (edge_det) begin
                case (state)
                    IDLE: begin
                        if (mark_start) state <= LEAD_MARK;
                    end
                    LEAD_MARK: begin
                        if (mark_end && w_lead_mark) begin
                            state <= LEAD_SPACE;
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end
                    LEAD_SPACE: begin
                        if (mark_start && w_lead_space) begin
                            state   <= BIT_MARK;
                            bit_cnt <= '0;
`ifdef IR_NEC_REPEAT_EN
                        end else if (mark_start && w_rep_space) begin
                            state <= REPEAT_MARK;
`endif
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end
                    BIT_MARK: begin
                        if (mark_end && w_bit_mark) begin
                            if (bit_cnt == 6'd32) begin
                                state <= IDLE;
                                if (cksum_ok) begin
`ifdef IR_NEC_REPEAT_EN
                                    last_frame <= shreg;
                                    last_valid <= 1'b1;
`endif
                                end else begin
                                    err <= 1'b1;
                                end
                            end else begin
                                state <= BIT_SPACE;
                            end
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end
                    BIT_SPACE: begin
                        if (mark_start && (w_zero || w_one)) begin
                            state   <= BIT_MARK;
                            shreg   <= {w_one, shreg[31:1]};
                            bit_cnt <= bit_cnt + 6'd1;
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end
`ifdef IR_NEC_REPEAT_EN
                    REPEAT_MARK: begin
                        state <= IDLE;
                        if (!(mark_end && w_bit_mark) || !last_valid) err <= 1'b1;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, accept;

    assign frame_valid = (count != '0);
    assign full        = (count == (AW + 1)'(DEPTH));
    assign pop         = frame_valid && frame_ready;
    assign accept      = push_req && (!full || pop);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req && !accept;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_entry;
    end

    assign frame_data = frame_valid ? mem[rd_ptr][31:0] : '0;
`ifdef IR_NEC_REPEAT_EN
    assign frame_repeat = frame_valid && mem[rd_ptr][32];
`else
    assign frame_repeat = 1'b0;
`endif

endmodule
